muldiv_seq: RTL

//  Iterative multi-cycle multiply/divide engine, N-bit operands. Sits directly

---
 rtl/muldiv_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative multiply/divide engine feeding the HI/LO result register stage.
//   It performs one shift-add (multiply) or restoring shift-subtract (divide)
//   step per clock over N clocks. Divide by zero finishes one cycle after
//   accept and does not iterate.
//
// Configuration
//   MULDIV_SIGNED_EN  When defined, operands are two's complement. The engine
//                     iterates on magnitudes, then fixes the result signs as
//                     hi/lo are loaded. The quotient truncates toward zero and
//                     the remainder takes the sign of the dividend. When
//                     undefined, all arithmetic is unsigned.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only in IDLE or DONE
//   op           in   0 = multiply, 1 = divide
//   a            in   multiplicand / dividend (N bits)
//   b            in   multiplier / divisor (N bits)
//   busy         out  high while iterating
//   done         out  one-cycle pulse, hi/lo valid
//   hi           out  product high half / remainder
//   lo           out  product low half / quotient
//   div_by_zero  out  divide with b==0, held with the result
module muldiv_seq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [N-1:0]  acc_hi, acc_lo, opd;
  logic          is_div, neg_lo, neg_hi;
  logic          accept, zero_div, last_step;

  logic          a_neg, b_neg;
  logic [N-1:0]  a_mag, b_mag;

  logic [N:0]    mul_sum;
  logic [N-1:0]  mul_hi_n, mul_lo_n;
  logic [N:0]    div_shift, div_diff;
  logic          div_ge;
  logic [N-1:0]  div_hi_n, div_lo_n;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]  quo_fix, rem_fix;

  assign accept    = start && (state == IDLE || state == DONE);
  assign zero_div  = op && (b == '0);
  assign last_step = (state == RUN) && (count == CW'(1));

`ifdef MULDIV_SIGNED_EN
  assign a_neg = a[N-1];
  assign b_neg = b[N-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // The most-negative value has no positive counterpart. Its magnitude
  // still comes out correct when the N bits are read as unsigned.
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration step for each operation, plus the sign-corrected final
  // results. The final results are computed from the step output so that
  // hi/lo can load on the same edge that enters DONE.
  always_comb begin
    // Multiply: the accumulator is {acc_hi, acc_lo}. acc_lo starts as the
    // multiplier and is shifted out LSB-first, while opd is the multiplicand.
    mul_sum              = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    {mul_hi_n, mul_lo_n} = {mul_sum, acc_lo[N-1:1]};

    // Divide: acc_hi is the partial remainder. acc_lo shifts the dividend
    // out MSB-first and shifts quotient bits in at the bottom.
    div_shift = {acc_hi, acc_lo[N-1]};
    div_diff  = div_shift - {1'b0, opd};
    div_ge    = (div_shift >= {1'b0, opd});
    div_hi_n  = div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
    div_lo_n  = {acc_lo[N-2:0], div_ge};

    prod_fix = neg_lo ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
    quo_fix  = neg_lo ? -div_lo_n : div_lo_n;
    rem_fix  = neg_hi ? -div_hi_n : div_hi_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = zero_div ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = zero_div ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands are latched on accept. Each RUN cycle performs one
  // step. The result registers change only on accept (div_by_zero) and on
  // the final step, so they hold through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opd         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      is_div <= op;
      count  <= CW'(N);
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= op & a_neg;
      acc_hi <= '0;
      acc_lo <= op ? a_mag : b_mag;
      opd    <= op ? b_mag : a_mag;
      if (zero_div) begin
        hi          <= a;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      count  <= count - CW'(1);
      acc_hi <= is_div ? div_hi_n : mul_hi_n;
      acc_lo <= is_div ? div_lo_n : mul_lo_n;
      if (last_step) begin
        hi <= is_div ? rem_fix : prod_fix[2*N-1:N];
        lo <= is_div ? quo_fix : prod_fix[N-1:0];
      end
    end
  end

endmodule
